ibex_instr_bus_arbiter: RTL and testbench

Two-to-one arbiter sharing one instruction-side memory port between two Ibex-protocol instruction masters. Typical masters are the core fetch unit and a boot loader or debug fetch path. The block sits between the masters and the instruction RAM or ROM. It does round-robin arbitration on the request/grant phase and tracks in-flight transactions in an ID FIFO. Each response (rvalid, rdata, rdata_intg, err) goes back to the master that issued the matching request, in issue order.

---
 rtl/ibex_instr_bus_arbiter_if.sv | 14 +
 rtl/ibex_instr_bus_arbiter.sv | 116 +++++++++++
 tb/tb_ibex_instr_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_instr_bus_arbiter_if.sv
// Ibex instruction-side bus: request/grant address phase plus response phase.
// The master modport drives the request; the slave modport answers it.
interface ibex_instr_bus;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, rdata_intg, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, rdata_intg, err);
endinterface

// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin 2:1 arbiter for Ibex instruction masters; zero-latency request/grant/response
// pass-through, ID FIFO routes responses in issue order, grants stall while the FIFO is full.
module ibex_instr_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  ibex_instr_bus.slave                         master0,
  ibex_instr_bus.slave                         master1,
  ibex_instr_bus.master                        slave,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 protocol_err
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       last_grant_q, last_grant_d;
  logic                       lock_valid_q, lock_valid_d;
  logic                       lock_id_q, lock_id_d;
  logic                       perr_q, perr_d;

  logic have_sel, sel, slv_req, full, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // A locked selection wins over fresh arbitration so the address holds across wait states.
  always_comb begin
    have_sel = 1'b1;
    sel      = 1'b0;
    if (lock_valid_q) begin
      sel = lock_id_q;
    end else if (master0.req && master1.req) begin
      sel = ~last_grant_q;
    end else if (master1.req) begin
      sel = 1'b1;
    end else if (!master0.req) begin
      have_sel = 1'b0;
    end
  end

  assign full    = (count_q == CW'(MAX_OUTSTANDING));
  assign slv_req = have_sel & (sel ? master1.req : master0.req) & ~full;
  assign push    = slv_req & slave.gnt;
  assign pop     = slave.rvalid & (count_q != '0);
  assign head    = fifo_q[rd_ptr_q];

  assign slave.req  = slv_req;
  assign slave.addr = (have_sel && sel) ? master1.addr : master0.addr;

  assign master0.gnt = push & ~sel;
  assign master1.gnt = push & sel;

  assign master0.rvalid     = pop & ~head;
  assign master1.rvalid     = pop & head;
  assign master0.err        = pop & ~head & slave.err;
  assign master1.err        = pop & head & slave.err;
  assign master0.rdata      = slave.rdata;
  assign master1.rdata      = slave.rdata;
  assign master0.rdata_intg = slave.rdata_intg;
  assign master1.rdata_intg = slave.rdata_intg;

  assign outstanding  = count_q;
  assign protocol_err = perr_q;

  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      last_grant_d     = sel;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A dropped request from the locked master releases the lock because slv_req falls.
    lock_valid_d = slv_req & ~slave.gnt;
    lock_id_d    = lock_valid_d ? sel : lock_id_q;
    perr_d       = perr_q | (slave.rvalid & (count_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_id_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      perr_q       <= perr_d;
    end
  end
endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Randomized and directed bench for ibex_instr_bus_arbiter against a queue-based reference model.
module tb_ibex_instr_bus_arbiter;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_instr_bus m0 ();
  ibex_instr_bus m1 ();
  ibex_instr_bus s ();
  logic [1:0] outstanding;
  logic       protocol_err;

  ibex_instr_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .master0(m0), .master1(m1), .slave(s),
    .outstanding(outstanding), .protocol_err(protocol_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owners of in-flight requests in issue order.
  int q[$];
  bit lg = 1'b1;
  bit lk = 1'b0;
  bit lk_id = 1'b0;
  bit perr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, outputs vs model, then advance the model.
  initial begin
    bit r0, r1, have, sl, fl, e_req, hsk;
    bit e_rv0, e_rv1, e_er0, e_er1;
    bit [31:0] e_addr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        lg = 1'b1; lk = 1'b0; lk_id = 1'b0; perr = 1'b0;
        chk("rst_slave_req", 32'(s.req), 32'd0);
        chk("rst_gnt", 32'({m0.gnt, m1.gnt}), 32'd0);
        chk("rst_rvalid", 32'({m0.rvalid, m1.rvalid}), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_protocol_err", 32'(protocol_err), 32'd0);
      end else begin
        r0 = m0.req; r1 = m1.req;
        have = lk || r0 || r1;
        if (lk) sl = lk_id;
        else if (r0 && r1) sl = !lg;
        else sl = r1;
        fl = (q.size() == MAXO);
        e_req = have && (sl ? r1 : r0) && !fl;
        e_addr = (have && sl) ? m1.addr : m0.addr;
        hsk = e_req && s.gnt;
        e_rv0 = 0; e_rv1 = 0; e_er0 = 0; e_er1 = 0;
        if (s.rvalid && q.size() > 0) begin
          if (q[0] == 0) begin e_rv0 = 1; e_er0 = s.err; end
          else begin e_rv1 = 1; e_er1 = s.err; end
        end
        chk("slave_req", 32'(s.req), 32'(e_req));
        chk("slave_addr", s.addr, e_addr);
        chk("gnt0", 32'(m0.gnt), 32'(hsk && !sl));
        chk("gnt1", 32'(m1.gnt), 32'(hsk && sl));
        chk("rvalid0", 32'(m0.rvalid), 32'(e_rv0));
        chk("rvalid1", 32'(m1.rvalid), 32'(e_rv1));
        chk("err0", 32'(m0.err), 32'(e_er0));
        chk("err1", 32'(m1.err), 32'(e_er1));
        chk("rdata0", m0.rdata, s.rdata);
        chk("rdata1", m1.rdata, s.rdata);
        chk("intg", 32'({m0.rdata_intg, m1.rdata_intg}), 32'({s.rdata_intg, s.rdata_intg}));
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        chk("protocol_err", 32'(protocol_err), 32'(perr));
        if (s.rvalid) begin
          if (q.size() > 0) void'(q.pop_front());
          else perr = 1'b1;
        end
        if (hsk) begin
          q.push_back(int'(sl));
          lg = sl;
        end
        lk = e_req && !s.gnt;
        if (lk) lk_id = sl;
      end
    end
  end

  task automatic idle();
    m0.req = 0; m0.addr = '0; m1.req = 0; m1.addr = '0;
    s.gnt = 0; s.rvalid = 0; s.rdata = '0; s.rdata_intg = '0; s.err = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0] rd_tab [4];

  initial begin
    bit p0, p1, g0, g1;
    rd_tab = '{32'hA0, 32'hB1, 32'hA2, 32'hB3};
    idle();
    step();
    do_reset();

    // Single master, immediate grant, response next cycle.
    step(); m0.req = 1; m0.addr = 32'h100; s.gnt = 1;
    neg();
    chk("t1_gnt0", 32'(m0.gnt), 32'd1);
    chk("t1_gnt1", 32'(m1.gnt), 32'd0);
    chk("t1_addr", s.addr, 32'h100);
    chk("t1_out0", 32'(outstanding), 32'd0);
    step(); m0.req = 0; s.gnt = 0; s.rvalid = 1; s.rdata = 32'hDEADBEEF;
    neg();
    chk("t1_rvalid0", 32'(m0.rvalid), 32'd1);
    chk("t1_rdata0", m0.rdata, 32'hDEADBEEF);
    chk("t1_rvalid1", 32'(m1.rvalid), 32'd0);
    chk("t1_out1", 32'(outstanding), 32'd1);
    step(); idle();
    neg();
    chk("t1_out2", 32'(outstanding), 32'd0);

    // Contention: alternating grants starting with master0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      m0.req = (k < 4); m0.addr = 32'h1000; m1.req = (k < 4); m1.addr = 32'h2000;
      s.gnt = 1; s.rvalid = (k > 0); s.rdata = (k > 0) ? rd_tab[k-1] : 32'h0;
      neg();
      if (k < 4) begin
        chk("t2_gnt0", 32'(m0.gnt), 32'(k % 2 == 0));
        chk("t2_gnt1", 32'(m1.gnt), 32'(k % 2 == 1));
      end
      if (k > 0) begin
        chk("t2_rv0", 32'(m0.rvalid), 32'((k - 1) % 2 == 0));
        chk("t2_rv1", 32'(m1.rvalid), 32'((k - 1) % 2 == 1));
        chk("t2_rdata", ((k - 1) % 2 == 0) ? m0.rdata : m1.rdata, rd_tab[k-1]);
      end
    end
    step(); idle();

    // Wait states: address held for master1 while master0 joins.
    do_reset();
    step(); m1.req = 1; m1.addr = 32'h300;
    neg(); chk("t3_addr_c0", s.addr, 32'h300); chk("t3_req_c0", 32'(s.req), 32'd1);
    step(); m0.req = 1; m0.addr = 32'h200;
    neg(); chk("t3_addr_c1", s.addr, 32'h300);
    step();
    neg(); chk("t3_addr_c2", s.addr, 32'h300);
    step(); s.gnt = 1;
    neg(); chk("t3_gnt1", 32'(m1.gnt), 32'd1); chk("t3_gnt0_lo", 32'(m0.gnt), 32'd0);
    step(); m1.req = 0;
    neg(); chk("t3_gnt0", 32'(m0.gnt), 32'd1); chk("t3_addr_m0", s.addr, 32'h200);
    step(); m0.req = 0; s.gnt = 0; s.rvalid = 1;
    neg(); chk("t3_resp_m1", 32'(m1.rvalid), 32'd1);
    step();
    neg(); chk("t3_resp_m0", 32'(m0.rvalid), 32'd1);
    step(); idle();

    // Full FIFO blocks the third request until a response frees an entry.
    do_reset();
    step(); m0.req = 1; m0.addr = 32'h10; s.gnt = 1;
    step(); m0.addr = 32'h14;
    step(); m0.req = 0; m1.req = 1; m1.addr = 32'h20;
    neg(); chk("t4_req_full", 32'(s.req), 32'd0); chk("t4_out_full", 32'(outstanding), 32'd2);
    step(); s.rvalid = 1;
    neg(); chk("t4_req_full_rv", 32'(s.req), 32'd0); chk("t4_rv0", 32'(m0.rvalid), 32'd1);
    step(); s.rvalid = 0;
    neg(); chk("t4_gnt1", 32'(m1.gnt), 32'd1); chk("t4_out1", 32'(outstanding), 32'd1);
    step(); m1.req = 0; s.gnt = 0; s.rvalid = 1;
    step();
    step(); idle();

    // Error routed to master1 only.
    do_reset();
    step(); m1.req = 1; m1.addr = 32'h40; s.gnt = 1;
    step(); m1.req = 0; s.gnt = 0; s.rvalid = 1; s.err = 1;
    neg();
    chk("t5_err1", 32'(m1.err), 32'd1);
    chk("t5_err0", 32'(m0.err), 32'd0);
    chk("t5_rv1", 32'(m1.rvalid), 32'd1);
    step(); idle();

    // Orphan response sets the sticky error.
    do_reset();
    step(); s.rvalid = 1; s.rdata = 32'h55;
    neg(); chk("t6_rv", 32'({m0.rvalid, m1.rvalid}), 32'd0);
    step(); idle();
    neg(); chk("t6_perr", 32'(protocol_err), 32'd1);
    step();
    neg(); chk("t6_perr_held", 32'(protocol_err), 32'd1);
    step(); rst_n = 1'b0;
    neg(); chk("t6_perr_rst", 32'(protocol_err), 32'd0);
    step(); rst_n = 1'b1;

    // Randomized traffic, including lock-drop violations and a mid-run reset.
    p0 = 0; p1 = 0; g0 = 0; g1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        p0 = 0; p1 = 0; g0 = 0; g1 = 0;
      end
      step();
      if (!(p0 && !g0) || ($urandom % 40 == 0)) begin
        p0 = ($urandom % 2 == 0);
        m0.addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(p1 && !g1) || ($urandom % 40 == 0)) begin
        p1 = ($urandom % 2 == 0);
        m1.addr = $urandom & 32'hFFFF_FFFC;
      end
      m0.req = p0;
      m1.req = p1;
      s.gnt = ($urandom % 4 != 0);
      s.rvalid = (q.size() > 0) && ($urandom % 2 == 0);
      s.rdata = $urandom;
      s.rdata_intg = 7'($urandom);
      s.err = ($urandom % 8 == 0);
      neg();
      g0 = m0.gnt;
      g1 = m1.gnt;
    end
    step(); idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
